tick_sched: RTL



---
 rtl/tick_sched_pkg.sv | 17 +
 rtl/tick_phase_cnt.sv | 34 +++
 rtl/tick_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared definitions for the tick scheduler.
//   - default widths for the phase counter and the repeat counter
//   - FSM state encoding (kept as plain 2-bit constants so the encoding is
//     visible on the state_dbg port)
package tick_sched_pkg;

    localparam int CNT_W_DEF = 10;
    localparam int REP_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/tick_phase_cnt.sv
// tick_phase_cnt: phase counter for the tick scheduler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force phase to 0 (has priority over en)
//   en         : advance one step; wraps to 0 when phase == per
//   per        : terminal phase value
//   hit        : phase currently equals per (the step taken now wraps)
module tick_phase_cnt
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] per,
    output logic             hit
);

    logic [CNT_W-1:0] phase_q;

    assign hit = (phase_q == per);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else if (clr) begin
            phase_q <= '0;
        end else if (en) begin
            phase_q <= hit ? '0 : phase_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tick_sched.sv
// tick_sched: programmable tick scheduler.
//   clk, rst_n  : clock, asynchronous active-low reset
//   cfg_period  : terminal phase; a tick every cfg_period+1 counting cycles
//   cfg_repeat  : ticks per burst, 0 = unlimited
//   start       : level; begins a run from IDLE (ignored while stop is high)
//   pause       : level; freezes the phase while high
//   stop        : level; aborts the run, tick_cnt keeps its value
//   tick        : registered one-cycle hit pulse
//   busy        : high in RUN or HOLD
//   done        : registered one-cycle pulse when a finite burst completes
//   tick_cnt    : ticks issued in the current/last run (wraps in unlimited mode)
//   state_dbg   : current FSM state (IDLE/RUN/HOLD/DONE encoding from the package)
//
// Control inputs are plain levels sampled on every rising edge; there is no
// handshake. Config is latched on the accepted start edge only.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] tick_cnt,
    output logic [1:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_q;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             load;
    logic             step;
    logic             phase_clr;
    logic             hit;

    // REP_W-bit sum so rep_q = 2^REP_W-1 is reachable and unlimited mode wraps.
    assign cnt_inc = cnt_q + REP_W'(1);

    tick_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_clr),
        .en    (step),
        .per   (per_q),
        .hit   (hit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        phase_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    load      = 1'b1;
                    phase_clr = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    phase_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    step = 1'b1;
                end
            end
            ST_HOLD: begin
                // The release edge counts as a normal RUN step, so the tick
                // is delayed by exactly the number of edges pause was high.
                if (stop) begin
                    phase_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (!pause) begin
                    step = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (step) begin
            state_d = ST_RUN;
            if (hit) begin
                tick_d = 1'b1;
                cnt_d  = cnt_inc;
                if (rep_q != '0 && cnt_inc == rep_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            per_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            if (load) begin
                per_q <= cfg_period;
                rep_q <= cfg_repeat;
            end
        end
    end

    assign tick      = tick_q;
    assign done      = done_q;
    assign tick_cnt  = cnt_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign state_dbg = state_q;

endmodule
